// File: rtl/data_mem_pkg.sv
// Shared definitions for the parameterised data memory: FSM encoding and read-latency bounds.
package data_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 4;

endpackage

// File: rtl/mem_read_pipe.sv
// Read response delay line: valid/data/error delayed by READ_LATENCY cycles, no backpressure.
// Data and error are zeroed at entry for idle slots, so the outputs read 0 whenever out_vld=0.
module mem_read_pipe #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  in_err,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  out_err
);

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] err_q, err_d;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    vld_d[0] = in_vld;
    err_d[0] = in_vld && in_err;
    dat_d[0] = in_vld ? in_dat : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign out_vld = vld_q[READ_LATENCY-1];
  assign out_err = err_q[READ_LATENCY-1];
  assign out_dat = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/param_data_memory.sv
// Byte-enabled word memory with in-order reads (READ_LATENCY cycles) and a DEPTH-cycle zero-fill sweep.
// req_ready drops while sweeping or when mem_clear is raised; responses cannot be stalled.
module param_data_memory
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    mem_clear,
  output logic                    busy,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   read_data_mem,
  output logic                    resp_error
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Unsupported latencies are clamped into the range the pipe is built for.
  localparam int unsigned PIPE_LAT = (READ_LATENCY < READ_LAT_MIN) ? READ_LAT_MIN :
                                     (READ_LATENCY > READ_LAT_MAX) ? READ_LAT_MAX : READ_LATENCY;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic [CNT_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  wr_en;
  logic [CNT_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == CLEAR);
    req_ready = (state_q == IDLE) && !mem_clear;
  end

  always_comb begin
    accept   = req_valid && req_ready;
    in_range = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
    req_idx  = address[CNT_W-1:0];
    cur_word = in_range ? mem[req_idx] : '0;
    for (int i = 0; i < BE_W; i++) lane_mask[8*i +: 8] = {8{byte_en[i]}};

    wr_en  = 1'b0;
    wr_idx = req_idx;
    wr_dat = (cur_word & ~lane_mask) | (write_data & lane_mask);
    // A reset landing mid-sweep must leave the current word untouched.
    if (state_q == CLEAR) begin
      wr_en  = !reset;
      wr_idx = cnt_q;
      wr_dat = '0;
    end else if (accept && req_write && in_range) begin
      wr_en = 1'b1;
    end

    rd_vld = accept && !req_write;
    rd_dat = cur_word;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  mem_read_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (PIPE_LAT)
  ) u_read_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_vld),
    .in_dat  (rd_dat),
    .in_err  (!in_range),
    .out_vld (resp_valid),
    .out_dat (read_data_mem),
    .out_err (resp_error)
  );

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: shadow model, expected reads queued at acceptance.
module tb_param_data_memory;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [1:0]    byte_en;
  logic          mem_clear, busy;
  logic          resp_valid, resp_error;
  logic [DW-1:0] read_data_mem;

  param_data_memory #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .address       (address),
    .write_data    (write_data),
    .byte_en       (byte_en),
    .mem_clear     (mem_clear),
    .busy          (busy),
    .resp_valid    (resp_valid),
    .read_data_mem (read_data_mem),
    .resp_error    (resp_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            c;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("resp_data", 32'(read_data_mem), 32'(e.d));
        chk("resp_err", 32'(resp_error), 32'(e.e));
        chk("resp_latency", 32'(cyc), 32'(e.c));
      end
    end else begin
      chk("idle_zero", {15'd0, resp_error, read_data_mem}, 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the request is accepted on the following edge.
  task automatic req(input logic wr, input int addr, input logic [DW-1:0] dat, input logic [1:0] be);
    exp_t e;
    req_valid  = 1'b1;
    req_write  = wr;
    address    = AW'(addr);
    write_data = dat;
    byte_en    = be;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (wr) begin
      if (addr < DEPTH)
        for (int b = 0; b < 2; b++)
          if (be[b]) model[addr][8*b +: 8] = dat[8*b +: 8];
    end else begin
      e.d = '0;
      if (addr < DEPTH) e.d = model[addr];
      e.e = (addr >= DEPTH);
      e.c = cyc + LAT - 1;
      sbq.push_back(e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; address = '0;
    write_data = '0; byte_en = '0; mem_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Clear sweep with a simultaneous write request that must be refused
    mem_clear = 1'b1; req_valid = 1'b1; req_write = 1'b1; address = 16'd5;
    write_data = 16'hDEAD; byte_en = 2'b11;
    @(negedge clk);
    chk("clr_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    mem_clear = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_ready", 32'(req_ready), 32'd0);
      mem_clear = (i == 100);
    end
    @(negedge clk);
    chk("sweep_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    for (int a = 0; a < DEPTH; a++) req(1'b0, a, '0, 2'b00);

    // Full and partial byte-lane writes
    req(1'b1, 2, 16'hF0F0, 2'b11);
    req(1'b0, 2, '0, 2'b00);
    req(1'b1, 2, 16'h1234, 2'b01);
    req(1'b0, 2, '0, 2'b00);
    req(1'b1, 2, 16'hABCD, 2'b10);
    req(1'b0, 2, '0, 2'b00);

    // Back-to-back reads
    req(1'b1, 1, 16'h1111, 2'b11);
    req(1'b1, 3, 16'h3333, 2'b11);
    req(1'b0, 1, '0, 2'b00);
    req(1'b0, 2, '0, 2'b00);
    req(1'b0, 3, '0, 2'b00);

    // Out-of-range: error read, dropped write that would alias word 44
    req(1'b1, 44, 16'h4444, 2'b11);
    req(1'b0, 300, '0, 2'b00);
    req(1'b1, 300, 16'hBEEF, 2'b11);
    req(1'b0, 44, '0, 2'b00);
    req(1'b0, 255, '0, 2'b00);

    for (int i = 0; i < 60; i++) begin
      req(1'($urandom_range(0, 1)), int'($urandom_range(0, 300)),
          DW'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Read in flight at sweep start, then reset 10 cycles into the sweep
    req(1'b1, 200, 16'h5A5A, 2'b11);
    req(1'b1, 7, 16'h7777, 2'b11);
    req(1'b1, 9, 16'h9999, 2'b11);
    req(1'b0, 200, '0, 2'b00);
    mem_clear = 1'b1;
    @(posedge clk); #1;
    mem_clear = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int a = 0; a < 10; a++) model[a] = '0;
    for (int a = 0; a < 10; a++) req(1'b0, a, '0, 2'b00);
    req(1'b0, 200, '0, 2'b00);
    idle(4);

    // A read accepted just before reset must never respond
    req_valid = 1'b1; req_write = 1'b0; address = 16'd200;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    req(1'b0, 200, '0, 2'b00);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 16, width of the word address.
REQ-003 Parameter DEPTH, default 256, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 2, cycles from read acceptance to response; legal range 1..4.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present this cycle.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 address  in  ADDR_WIDTH  word address.
REQ-011 write_data  in  DATA_WIDTH  write data.
REQ-012 byte_en  in  DATA_WIDTH/8  per-byte write enable; bit i covers bits 8i+7..8i.
REQ-013 mem_clear  in  1  start a zero-fill sweep of the whole array.
REQ-014 busy  out  1  zero-fill sweep in progress.
REQ-015 resp_valid  out  1  read response valid.
REQ-016 read_data_mem  out  DATA_WIDTH  read response data.
REQ-017 resp_error  out  1  response refers to an out-of-range address.

Function
REQ-018 The block SHALL accept a request on any edge where req_valid && req_ready.
REQ-019 req_ready SHALL equal (state==IDLE) && !mem_clear.
REQ-020 The FSM SHALL have two states: IDLE and CLEAR.
REQ-021 IDLE -> CLEAR on mem_clear=1; the sweep counter loads 0 and busy asserts the next cycle.
REQ-022 In CLEAR the block SHALL write 0 to word[counter] each cycle and increment the counter.
REQ-023 The block SHALL return CLEAR -> IDLE after writing word DEPTH-1, so a sweep lasts exactly DEPTH cycles.
REQ-024 mem_clear SHALL be ignored while in CLEAR.
REQ-025 An accepted write SHALL update only the byte lanes with byte_en=1, and SHALL commit at the accepting edge.
REQ-026 Writes SHALL produce no response.
REQ-027 An accepted read SHALL produce exactly one resp_valid pulse READ_LATENCY cycles after acceptance; full throughput is one read per cycle.
REQ-028 Responses SHALL be returned in acceptance order.
REQ-029 read_data_mem SHALL hold the word value sampled at the accepting edge, including any write committed at an earlier edge.
REQ-030 Address >= DEPTH: a write SHALL be dropped; a read SHALL respond with data 0 and resp_error=1.
REQ-031 Reads already in the pipeline when CLEAR starts SHALL complete with their sampled data.
REQ-032 When resp_valid=0, read_data_mem and resp_error SHALL be 0.

Reset
REQ-033 Reset SHALL force state IDLE, busy=0, the sweep counter to 0, all pipeline valid bits to 0, and resp_valid, read_data_mem and resp_error to 0.
REQ-034 Reset SHALL NOT alter the memory array.
REQ-035 Reset during CLEAR SHALL abort the sweep; unswept words keep their values.
REQ-036 In-flight reads SHALL be discarded on reset.

Structure
REQ-037 A shared package data_mem_pkg SHALL hold the state encoding (IDLE, CLEAR) and the READ_LATENCY bounds (1 and 4).
REQ-038 The valid/data/error delay line SHALL be a sub-module mem_read_pipe, parametrised by DATA_WIDTH and READ_LATENCY.
REQ-039 The array SHALL be inferred as a synchronous-write register array.

Verification
REQ-040 Write addr 2 = 0xF0F0 with byte_en=2'b11, then read addr 2 (READ_LATENCY=2) -> resp_valid exactly 2 cycles after acceptance, read_data_mem=0xF0F0, resp_error=0.
REQ-041 Write addr 2 = 0x1234 with byte_en=2'b01, then read addr 2 -> 0xF034.
REQ-042 Back-to-back reads of addr 1, 2, 3 on consecutive cycles -> three consecutive resp_valid cycles returning the data in address order.
REQ-043 DEPTH=256: read addr 300 -> data 0, resp_error=1; write addr 300 -> no array change.
REQ-044 Pulse mem_clear with req_valid=1 in the same cycle -> request not accepted; busy and req_ready=0 for 256 cycles; all words then read 0.
REQ-045 Assert reset at cycle 10 of a sweep -> busy=0 next cycle, words 0..9 read 0, word 200 retains its prior value.
